// File: rtl/wide_narrow_rsp_router.sv
`default_nettype none
// ============================================================================
// Module   : wide_narrow_rsp_router
// Purpose  : Routes narrow (per-bank) and wide (bank-group) requests onto a
//            row of narrow SRAM banks, tracks each accepted request through a
//            SramLatency-deep tag pipeline per bank and returns the read data
//            (or a zero write acknowledge) on the port that issued it.
//            A narrow request on any bank of a group wins over a wide request
//            to that group in the same cycle; the wide request is dropped
//            entirely and never produces a response.
// Ports    : clk_i, rst_i                 clock, asynchronous active-high reset
//            narrow_*_i                   per-bank narrow request + grant
//            wide_*_i                     per-group wide request + grant
//            sram_*_o / sram_rdata_i      per-bank SRAM macro interface
//            narrow_rsp_*_o               per-bank narrow response
//            wide_rsp_*_o                 per-group wide response
//            err_o                        sticky narrow/wide grant conflict
// Options  : WIDE_NARROW_RSP_ROUTER_CONFLICT_CHECK_EN
//            defined   -> err_o is a sticky register set on a conflict
//            undefined -> err_o tied low, routing unchanged
// Revision : 1.0  initial release
// ============================================================================
module wide_narrow_rsp_router #(
    parameter int NumNarrowBanks  = 8,
    parameter int NumWideBanks    = 2,
    parameter int NarrowDataWidth = 64,
    parameter int AddrWidth       = 12,
    parameter int SramLatency     = 1,
    localparam int c_NARROW_PER_WIDE = NumNarrowBanks / NumWideBanks,
    localparam int c_WIDE_DW         = NarrowDataWidth * c_NARROW_PER_WIDE,
    localparam int c_NARROW_BW       = NarrowDataWidth / 8,
    localparam int c_WIDE_BW         = c_WIDE_DW / 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,

    input  logic [NumNarrowBanks-1:0]                     narrow_valid_i,
    input  logic [NumNarrowBanks-1:0]                     narrow_ready_i,
    input  logic [NumNarrowBanks-1:0]                     narrow_we_i,
    input  logic [NumNarrowBanks-1:0][AddrWidth-1:0]      narrow_addr_i,
    input  logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0] narrow_wdata_i,
    input  logic [NumNarrowBanks-1:0][c_NARROW_BW-1:0]    narrow_be_i,

    input  logic [NumWideBanks-1:0]                       wide_valid_i,
    input  logic [NumWideBanks-1:0]                       wide_ready_i,
    input  logic [NumWideBanks-1:0]                       wide_we_i,
    input  logic [NumWideBanks-1:0][AddrWidth-1:0]        wide_addr_i,
    input  logic [NumWideBanks-1:0][c_WIDE_DW-1:0]        wide_wdata_i,
    input  logic [NumWideBanks-1:0][c_WIDE_BW-1:0]        wide_be_i,

    output logic [NumNarrowBanks-1:0]                     sram_req_o,
    output logic [NumNarrowBanks-1:0]                     sram_we_o,
    output logic [NumNarrowBanks-1:0][AddrWidth-1:0]      sram_addr_o,
    output logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0] sram_wdata_o,
    output logic [NumNarrowBanks-1:0][c_NARROW_BW-1:0]    sram_be_o,
    input  logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0] sram_rdata_i,

    output logic [NumNarrowBanks-1:0]                     narrow_rsp_valid_o,
    output logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0] narrow_rsp_data_o,
    output logic [NumWideBanks-1:0]                       wide_rsp_valid_o,
    output logic [NumWideBanks-1:0][c_WIDE_DW-1:0]        wide_rsp_data_o,

    output logic                                          err_o
);

    // Per-bank in-flight tag. 'we' is carried so a write completes with
    // zero data instead of whatever the macro happens to drive.
    typedef struct packed {
        logic valid;
        logic is_wide;
        logic we;
    } tag_t;

    logic [NumNarrowBanks-1:0] w_narrow_acc;
    logic [NumWideBanks-1:0]   w_wide_req;
    logic [NumWideBanks-1:0]   w_group_busy;
    logic [NumWideBanks-1:0]   w_wide_acc;
    tag_t                      w_tail [NumNarrowBanks];

    assign w_narrow_acc = narrow_valid_i & narrow_ready_i;
    assign w_wide_req   = wide_valid_i & wide_ready_i;

    // ------------------------------------------------------------------
    // Group-level arbitration: any narrow access inside a group kills the
    // wide access for every bank of that group, so a wide write is never
    // partially committed and a wide read never returns a torn word.
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < NumWideBanks; j++) begin : g_group
            logic [c_WIDE_DW-1:0] w_group_rdata;
            tag_t                 w_group_tag;

            assign w_group_busy[j] = |w_narrow_acc[j*c_NARROW_PER_WIDE +: c_NARROW_PER_WIDE];
            assign w_wide_acc[j]   = w_wide_req[j] & ~w_group_busy[j];

            // All banks of a group carry identical wide tags; the base bank
            // is representative. Bank group_base lands at the LSB.
            assign w_group_tag   = w_tail[j*c_NARROW_PER_WIDE];
            assign w_group_rdata = sram_rdata_i[j*c_NARROW_PER_WIDE +: c_NARROW_PER_WIDE];

            assign wide_rsp_valid_o[j] = w_group_tag.valid & w_group_tag.is_wide;
            assign wide_rsp_data_o[j]  = (wide_rsp_valid_o[j] & ~w_group_tag.we)
                                         ? w_group_rdata : '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-bank request mux, tag pipeline and narrow response.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NumNarrowBanks; i++) begin : g_bank
            localparam int c_GRP = i / c_NARROW_PER_WIDE;
            localparam int c_SLC = i % c_NARROW_PER_WIDE;

            logic w_use_wide;
            tag_t w_tag_in;
            tag_t r_tag [SramLatency];

            assign w_use_wide = ~w_narrow_acc[i] & w_wide_acc[c_GRP];

            assign sram_req_o[i]   = w_narrow_acc[i] | w_wide_acc[c_GRP];
            assign sram_we_o[i]    = w_narrow_acc[i] ? narrow_we_i[i]
                                   : (w_use_wide & wide_we_i[c_GRP]);
            assign sram_addr_o[i]  = w_narrow_acc[i] ? narrow_addr_i[i]
                                   : w_use_wide     ? wide_addr_i[c_GRP] : '0;
            assign sram_wdata_o[i] = w_narrow_acc[i] ? narrow_wdata_i[i]
                                   : w_use_wide
                                     ? wide_wdata_i[c_GRP][c_SLC*NarrowDataWidth +: NarrowDataWidth]
                                     : '0;
            assign sram_be_o[i]    = w_narrow_acc[i] ? narrow_be_i[i]
                                   : w_use_wide
                                     ? wide_be_i[c_GRP][c_SLC*c_NARROW_BW +: c_NARROW_BW]
                                     : '0;

            // Reads and writes both occupy a slot so every accepted request
            // gets exactly one response.
            assign w_tag_in = '{valid:   sram_req_o[i],
                                is_wide: w_use_wide,
                                we:      sram_we_o[i]};

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int k = 0; k < SramLatency; k++) begin
                        r_tag[k] <= '0;
                    end
                end else begin
                    r_tag[0] <= w_tag_in;
                    for (int k = 1; k < SramLatency; k++) begin
                        r_tag[k] <= r_tag[k-1];
                    end
                end
            end

            assign w_tail[i] = r_tag[SramLatency-1];

            assign narrow_rsp_valid_o[i] = w_tail[i].valid & ~w_tail[i].is_wide;
            assign narrow_rsp_data_o[i]  = (narrow_rsp_valid_o[i] & ~w_tail[i].we)
                                           ? sram_rdata_i[i] : '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Conflict flag
    // ------------------------------------------------------------------
`ifdef WIDE_NARROW_RSP_ROUTER_CONFLICT_CHECK_EN
    logic r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (|(w_wide_req & w_group_busy)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wide_narrow_rsp_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_narrow_rsp_router
// Purpose  : Self-checking bench for wide_narrow_rsp_router (8 narrow banks,
//            2 wide groups, 64-bit words, SRAM latency 2). A table of
//            one-cycle request vectors checks the SRAM-side routing; every
//            accepted request pushes its expected response into a scoreboard
//            that is compared cycle by cycle. Hand-written sequences cover
//            the grant conflict and a mid-flight reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_wide_narrow_rsp_router;

    localparam int N   = 8;
    localparam int W   = 2;
    localparam int DW  = 64;
    localparam int AW  = 12;
    localparam int L   = 2;
    localparam int WDW = 256;

`ifdef WIDE_NARROW_RSP_ROUTER_CONFLICT_CHECK_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    logic                    clk_i;
    logic                    rst_i;
    logic [N-1:0]            narrow_valid_i, narrow_ready_i, narrow_we_i;
    logic [N-1:0][AW-1:0]    narrow_addr_i;
    logic [N-1:0][DW-1:0]    narrow_wdata_i;
    logic [N-1:0][7:0]       narrow_be_i;
    logic [W-1:0]            wide_valid_i, wide_ready_i, wide_we_i;
    logic [W-1:0][AW-1:0]    wide_addr_i;
    logic [W-1:0][WDW-1:0]   wide_wdata_i;
    logic [W-1:0][31:0]      wide_be_i;
    logic [N-1:0]            sram_req_o, sram_we_o;
    logic [N-1:0][AW-1:0]    sram_addr_o;
    logic [N-1:0][DW-1:0]    sram_wdata_o;
    logic [N-1:0][7:0]       sram_be_o;
    logic [N-1:0][DW-1:0]    sram_rdata_i;
    logic [N-1:0]            narrow_rsp_valid_o;
    logic [N-1:0][DW-1:0]    narrow_rsp_data_o;
    logic [W-1:0]            wide_rsp_valid_o;
    logic [W-1:0][WDW-1:0]   wide_rsp_data_o;
    logic                    err_o;

    wide_narrow_rsp_router #(
        .NumNarrowBanks (N),
        .NumWideBanks   (W),
        .NarrowDataWidth(DW),
        .AddrWidth      (AW),
        .SramLatency    (L)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .narrow_valid_i    (narrow_valid_i),
        .narrow_ready_i    (narrow_ready_i),
        .narrow_we_i       (narrow_we_i),
        .narrow_addr_i     (narrow_addr_i),
        .narrow_wdata_i    (narrow_wdata_i),
        .narrow_be_i       (narrow_be_i),
        .wide_valid_i      (wide_valid_i),
        .wide_ready_i      (wide_ready_i),
        .wide_we_i         (wide_we_i),
        .wide_addr_i       (wide_addr_i),
        .wide_wdata_i      (wide_wdata_i),
        .wide_be_i         (wide_be_i),
        .sram_req_o        (sram_req_o),
        .sram_we_o         (sram_we_o),
        .sram_addr_o       (sram_addr_o),
        .sram_wdata_o      (sram_wdata_o),
        .sram_be_o         (sram_be_o),
        .sram_rdata_i      (sram_rdata_i),
        .narrow_rsp_valid_o(narrow_rsp_valid_o),
        .narrow_rsp_data_o (narrow_rsp_data_o),
        .wide_rsp_valid_o  (wide_rsp_valid_o),
        .wide_rsp_data_o   (wide_rsp_data_o),
        .err_o             (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------
    // SRAM bank model: L-cycle read pipeline, byte-enabled writes.
    // Unwritten words read a fixed pattern; idle pipeline slots carry
    // random junk so a write or idle slot can never look like valid data.
    // ------------------------------------------------------------------
    logic [DW-1:0] mem     [N][4096];
    bit            written [N][4096];
    logic [DW-1:0] pipe    [N][L];

    function automatic logic [DW-1:0] rd_model(input int b, input logic [AW-1:0] a);
        if (written[b][a]) return mem[b][a];
        if (b == 3 && a == 12'h010) return 64'hDEAD_BEEF;
        return {16'hB000 + 16'(b), 4'h0, a, (32'(a) * 32'h9E37_79B9) ^ 32'(b)};
    endfunction

    always @(posedge clk_i) begin
        for (int b = 0; b < N; b++) begin
            logic [DW-1:0] cur;
            for (int k = L - 1; k > 0; k--) pipe[b][k] = pipe[b][k-1];
            if (sram_req_o[b] && !sram_we_o[b]) pipe[b][0] = rd_model(b, sram_addr_o[b]);
            else                                pipe[b][0] = {$urandom, $urandom};
            if (sram_req_o[b] && sram_we_o[b]) begin
                cur = rd_model(b, sram_addr_o[b]);
                for (int y = 0; y < 8; y++)
                    if (sram_be_o[b][y]) cur[y*8 +: 8] = sram_wdata_o[b][y*8 +: 8];
                mem[b][sram_addr_o[b]]     = cur;
                written[b][sram_addr_o[b]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < N; b++) sram_rdata_i[b] = pipe[b][L-1];
    end

    // ------------------------------------------------------------------
    // Vectors, scoreboard, bookkeeping
    // ------------------------------------------------------------------
    typedef struct {
        logic [N-1:0]  n_valid, n_ready, n_we;
        logic [AW-1:0] n_addr;
        logic [W-1:0]  w_valid, w_ready, w_we;
        logic [AW-1:0] w_addr;
        logic [N-1:0]  exp_req, exp_we;
    } vec_t;

    typedef struct {
        int             due;
        bit             is_wide;
        int             port;
        logic [WDW-1:0] data;
    } sb_t;

    localparam int NROWS = 13;
    vec_t          tbl [NROWS];
    vec_t          v_tmp;
    sb_t           sb [$];
    int            cyc;
    int            n_checks;
    int            n_errors;
    logic [AW-1:0] exp_addr  [N];
    logic [DW-1:0] exp_wdata [N];

    task automatic chk(input bit ok, input string name,
                       input logic [WDW-1:0] act, input logic [WDW-1:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle();
        narrow_valid_i = '0; narrow_ready_i = '0; narrow_we_i = '0;
        narrow_addr_i  = '0; narrow_wdata_i = '0; narrow_be_i = '0;
        wide_valid_i   = '0; wide_ready_i   = '0; wide_we_i   = '0;
        wide_addr_i    = '0; wide_wdata_i   = '0; wide_be_i   = '0;
    endtask

    task automatic advance();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    // Drive one request vector and record every response it must produce.
    task automatic drive(input vec_t v);
        logic [N-1:0] nacc;
        logic [W-1:0] wraw, weff;
        sb_t          e;
        for (int i = 0; i < N; i++) begin
            narrow_valid_i[i] = v.n_valid[i];
            narrow_ready_i[i] = v.n_ready[i];
            narrow_we_i[i]    = v.n_we[i];
            narrow_addr_i[i]  = v.n_addr;
            narrow_wdata_i[i] = {$urandom, $urandom};
            narrow_be_i[i]    = 8'hFF;
        end
        for (int j = 0; j < W; j++) begin
            wide_valid_i[j] = v.w_valid[j];
            wide_ready_i[j] = v.w_ready[j];
            wide_we_i[j]    = v.w_we[j];
            wide_addr_i[j]  = v.w_addr;
            for (int c = 0; c < 8; c++) wide_wdata_i[j][c*32 +: 32] = $urandom;
            wide_be_i[j]    = '1;
        end
        nacc = v.n_valid & v.n_ready;
        wraw = v.w_valid & v.w_ready;
        for (int j = 0; j < W; j++) weff[j] = wraw[j] & ~(|nacc[j*4 +: 4]);
        for (int b = 0; b < N; b++) begin
            if (nacc[b]) begin
                exp_addr[b]  = v.n_addr;
                exp_wdata[b] = narrow_wdata_i[b];
            end else begin
                exp_addr[b]  = v.w_addr;
                exp_wdata[b] = wide_wdata_i[b/4][(b%4)*64 +: 64];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (nacc[i]) begin
                e.due = cyc + L; e.is_wide = 1'b0; e.port = i;
                e.data = v.n_we[i] ? '0 : WDW'(rd_model(i, v.n_addr));
                sb.push_back(e);
            end
        end
        for (int j = 0; j < W; j++) begin
            if (weff[j]) begin
                e.due = cyc + L; e.is_wide = 1'b1; e.port = j; e.data = '0;
                if (!v.w_we[j])
                    for (int k = 0; k < 4; k++) e.data[k*64 +: 64] = rd_model(j*4 + k, v.w_addr);
                sb.push_back(e);
            end
        end
    endtask

    task automatic check_comb(input vec_t v);
        chk(sram_req_o === v.exp_req, "sram_req", WDW'(sram_req_o), WDW'(v.exp_req));
        chk((sram_we_o & sram_req_o) === v.exp_we, "sram_we",
            WDW'(sram_we_o & sram_req_o), WDW'(v.exp_we));
        for (int b = 0; b < N; b++) begin
            if (v.exp_req[b])
                chk(sram_addr_o[b] === exp_addr[b], $sformatf("sram_addr[%0d]", b),
                    WDW'(sram_addr_o[b]), WDW'(exp_addr[b]));
            if (v.exp_we[b]) begin
                chk(sram_wdata_o[b] === exp_wdata[b], $sformatf("sram_wdata[%0d]", b),
                    WDW'(sram_wdata_o[b]), WDW'(exp_wdata[b]));
                chk(sram_be_o[b] === 8'hFF, $sformatf("sram_be[%0d]", b),
                    WDW'(sram_be_o[b]), WDW'(8'hFF));
            end
        end
        chk(err_o === 1'b0, "err_no_conflict", WDW'(err_o), '0);
    endtask

    // Compare response outputs against everything due this cycle.
    task automatic sb_check();
        logic [N-1:0] env;
        logic [W-1:0] ewv;
        sb_t          e;
        if (rst_i) begin
            chk(narrow_rsp_valid_o === '0 && wide_rsp_valid_o === '0 && err_o === 1'b0,
                "reset_valid_err", WDW'({narrow_rsp_valid_o, wide_rsp_valid_o, err_o}), '0);
            chk(narrow_rsp_data_o === '0 && wide_rsp_data_o === '0, "reset_data",
                WDW'(|{narrow_rsp_data_o, wide_rsp_data_o}), '0);
            sb.delete();
            return;
        end
        env = '0;
        ewv = '0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.is_wide) begin
                ewv[e.port] = 1'b1;
                chk(wide_rsp_data_o[e.port] === e.data, $sformatf("wide_rsp_data[%0d]", e.port),
                    wide_rsp_data_o[e.port], e.data);
            end else begin
                env[e.port] = 1'b1;
                chk(narrow_rsp_data_o[e.port] === e.data[DW-1:0],
                    $sformatf("narrow_rsp_data[%0d]", e.port),
                    WDW'(narrow_rsp_data_o[e.port]), e.data);
            end
        end
        chk(narrow_rsp_valid_o === env, "narrow_rsp_valid", WDW'(narrow_rsp_valid_o), WDW'(env));
        chk(wide_rsp_valid_o === ewv, "wide_rsp_valid", WDW'(wide_rsp_valid_o), WDW'(ewv));
    endtask

    initial begin
        //         n_valid n_ready n_we   n_addr   w_valid w_ready w_we   w_addr   exp_req exp_we
        tbl[0]  = '{8'h08, 8'h08, 8'h00, 12'h010, 2'b00, 2'b00, 2'b00, 12'h000, 8'h08, 8'h00};
        tbl[1]  = '{8'h00, 8'h00, 8'h00, 12'h000, 2'b10, 2'b10, 2'b10, 12'h020, 8'hF0, 8'hF0};
        tbl[2]  = '{8'h01, 8'h01, 8'h00, 12'h030, 2'b00, 2'b00, 2'b00, 12'h000, 8'h01, 8'h00};
        tbl[3]  = '{8'h00, 8'h00, 8'h00, 12'h000, 2'b01, 2'b01, 2'b00, 12'h031, 8'h0F, 8'h00};
        tbl[4]  = '{8'h01, 8'h01, 8'h00, 12'h032, 2'b00, 2'b00, 2'b00, 12'h000, 8'h01, 8'h00};
        tbl[5]  = '{8'h00, 8'h00, 8'h00, 12'h000, 2'b01, 2'b01, 2'b00, 12'h033, 8'h0F, 8'h00};
        tbl[6]  = '{8'h01, 8'h00, 8'h00, 12'h040, 2'b01, 2'b10, 2'b00, 12'h041, 8'h00, 8'h00};
        tbl[7]  = '{8'h40, 8'h40, 8'h40, 12'h040, 2'b01, 2'b01, 2'b00, 12'h041, 8'h4F, 8'h40};
        tbl[8]  = '{8'h20, 8'h20, 8'h00, 12'h020, 2'b00, 2'b00, 2'b00, 12'h000, 8'h20, 8'h00};
        tbl[9]  = '{8'hFF, 8'hFF, 8'h00, 12'h044, 2'b00, 2'b00, 2'b00, 12'h000, 8'hFF, 8'h00};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 12'h000, 2'b11, 2'b11, 2'b01, 12'h050, 8'hFF, 8'h0F};
        tbl[11] = '{8'h0F, 8'h0F, 8'h00, 12'h050, 2'b00, 2'b00, 2'b00, 12'h000, 8'h0F, 8'h00};
        tbl[12] = '{8'h40, 8'h40, 8'h00, 12'h040, 2'b00, 2'b00, 2'b00, 12'h000, 8'h40, 8'h00};

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_i    = 1'b1;
        idle();

        // Reset state
        repeat (2) begin
            @(negedge clk_i); sb_check(); advance();
        end
        rst_i = 1'b0;

        // Table vectors, back to back from the first cycle out of reset
        for (int r = 0; r < NROWS; r++) begin
            drive(tbl[r]);
            @(negedge clk_i); check_comb(tbl[r]); sb_check();
            advance();
        end
        idle();
        repeat (L + 1) begin
            @(negedge clk_i); sb_check(); advance();
        end

        // Narrow port 2 and wide port 0 granted together
        v_tmp = '{8'h04, 8'h04, 8'h00, 12'h050, 2'b01, 2'b01, 2'b00, 12'h052, 8'h04, 8'h00};
        drive(v_tmp);
        @(negedge clk_i);
        chk(sram_req_o[2] === 1'b1, "conflict_narrow_req", WDW'(sram_req_o[2]), WDW'(1));
        chk(sram_addr_o[2] === 12'h050, "conflict_narrow_addr", WDW'(sram_addr_o[2]), WDW'(12'h050));
        chk(err_o === 1'b0, "err_before_edge", WDW'(err_o), '0);
        sb_check();
        advance();
        idle();
        @(negedge clk_i);
        chk(err_o === ExpErr, "err_after_conflict", WDW'(err_o), WDW'(ExpErr));
        sb_check();
        advance();
        repeat (L + 1) begin
            @(negedge clk_i); sb_check(); advance();
        end

        // Reset pulse one cycle after a narrow read is accepted
        v_tmp = '{8'h08, 8'h08, 8'h00, 12'h010, 2'b00, 2'b00, 2'b00, 12'h000, 8'h08, 8'h00};
        drive(v_tmp);
        @(negedge clk_i); sb_check(); advance();
        idle();
        rst_i = 1'b1;
        @(negedge clk_i); sb_check(); advance();
        rst_i = 1'b0;
        v_tmp = '{8'h02, 8'h02, 8'h00, 12'h011, 2'b00, 2'b00, 2'b00, 12'h000, 8'h02, 8'h00};
        drive(v_tmp);
        @(negedge clk_i);
        chk(sram_req_o === 8'h02, "post_reset_req", WDW'(sram_req_o), WDW'(8'h02));
        sb_check();
        advance();
        idle();
        repeat (L + 2) begin
            @(negedge clk_i); sb_check(); advance();
        end

        chk(sb.size() == 0, "scoreboard_drained", WDW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wide_narrow_rsp_router.md
WIDE_NARROW_RSP_ROUTER -- requirements
Module: wide_narrow_rsp_router

Interface
REQ-001 SHALL have parameter NumNarrowBanks, default 8; number of narrow-granularity SRAM banks.
REQ-002 SHALL have parameter NumWideBanks, default 2; number of wide ports, each spanning NarrowPerWide = NumNarrowBanks/NumWideBanks adjacent banks.
REQ-003 SHALL have parameter NarrowDataWidth, default 64; bank word width, with wide width = NarrowDataWidth*NarrowPerWide.
REQ-004 SHALL have parameter AddrWidth, default 12; bank word address width.
REQ-005 SHALL have parameter SramLatency, default 1, legal 1..4; cycles from SRAM request to rdata.
REQ-006 SHALL have clk_i  in  1  sole clock, rising edge.
REQ-007 SHALL have rst_i  in  1  asynchronous, active-high reset.
REQ-008 SHALL have narrow_valid_i/narrow_ready_i  in  NumNarrowBanks each  request valid and arbiter grant per narrow port.
REQ-009 SHALL have narrow_we_i, narrow_addr_i, narrow_wdata_i, narrow_be_i  in  per port 1/AddrWidth/NarrowDataWidth/NarrowDataWidth/8  narrow request fields.
REQ-010 SHALL have wide_valid_i/wide_ready_i, wide_we_i, wide_addr_i, wide_wdata_i, wide_be_i  in  per wide port, wide-width data/strobe  wide request fields.
REQ-011 SHALL have sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o  out  per bank  SRAM macro request.
REQ-012 SHALL have sram_rdata_i  in  NarrowDataWidth per bank  SRAM read data.
REQ-013 SHALL have narrow_rsp_valid_o, narrow_rsp_data_o  out  per narrow port  response.
REQ-014 SHALL have wide_rsp_valid_o, wide_rsp_data_o  out  per wide port  response.
REQ-015 SHALL have err_o  out  1  sticky grant-conflict flag.

Function
REQ-016 SHALL treat a request as accepted only when valid and ready are both 1 in the same cycle.
REQ-017 SHALL, combinationally, drive bank i from narrow port i when accepted, else from slice (i mod NarrowPerWide) of wide port i/NarrowPerWide when accepted, else sram_req_o[i]=0.
REQ-018 SHALL, for wide requests, pass wide_addr_i unchanged to every bank in the group, with data/strobe slice k mapped to bank group_base+k.
REQ-019 SHALL keep per bank a SramLatency-deep tag shift register of {valid, is_wide}, loaded on every accepted request (read or write).
REQ-020 SHALL assert narrow_rsp_valid_o[i] exactly SramLatency cycles after acceptance, for one cycle per request, with narrow_rsp_data_o[i]=sram_rdata_i[i] for reads and 0 for writes.
REQ-021 SHALL assert wide_rsp_valid_o[j] SramLatency cycles after acceptance, data = concatenation of the group's sram_rdata_i, bank group_base at LSB, 0 for writes.
REQ-022 SHALL sustain one accepted request per port per cycle, back-to-back, with no bubbles.
REQ-023 SHALL, if narrow and wide are both accepted on one bank in the same cycle, serve narrow only, drop the wide request for the whole group (no wide response), and set err_o when checking is enabled.
REQ-024 SHALL never assert a response valid without a matching accepted request.

Reset
REQ-025 SHALL, while rst_i=1, clear all tag registers and drive all *_rsp_valid_o=0, *_rsp_data_o=0, err_o=0.
REQ-026 SHALL discard in-flight requests on reset mid-operation; no response for them after release.
REQ-027 SHALL accept requests in the first cycle after rst_i deasserts.

Configuration
REQ-028 SHALL, with WIDE_NARROW_RSP_ROUTER_CONFLICT_CHECK_EN defined, implement err_o as a register set by REQ-023 conflicts and cleared only by reset.
REQ-029 SHALL, without WIDE_NARROW_RSP_ROUTER_CONFLICT_CHECK_EN, tie err_o to 0 while REQ-023 routing is unchanged.

Verification (NumNarrowBanks=8, NumWideBanks=2, NarrowDataWidth=64, SramLatency=2)
REQ-030 SHALL cover narrow read port 3, addr 0x010, SRAM model returns 0xDEAD_BEEF -> narrow_rsp_valid_o[3]=1 exactly 2 cycles later with data 0xDEAD_BEEF.
REQ-031 SHALL cover wide write port 1, addr 0x020, be all-ones -> sram_req_o[4..7]=1 same cycle, wide_rsp_valid_o[1]=1 two cycles later with data 0.
REQ-032 SHALL cover alternating narrow port 0 / wide port 0 reads on 4 consecutive cycles -> 4 responses in issue order, one per cycle, no gaps.
REQ-033 SHALL cover narrow port 2 and wide port 0 both accepted in one cycle -> only narrow_rsp_valid_o[2] fires, err_o=1 with macro defined and 0 without.
REQ-034 SHALL cover rst_i pulsed 1 cycle after a narrow read acceptance -> no response, all outputs 0 until next accepted request.
